// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic job sequencer.
// Optional exact-hit bypass is enabled by defining BICUBIC_EXACT_BYPASS_EN.
package bicubic_pkg;

    localparam int IMG_W_DEF = 100;
    localparam int IMG_H_DEF = 100;
    localparam int IMG_AW = 14;
    localparam int RES_AW = 16;

    // Q0.8 weight that stands in for 1.0
    localparam logic [7:0] Q8_ONE = 8'd255;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_STEP_Y,
        S_DIV_Y,
        S_STEP_X,
        S_DIV_X,
        S_POW,
        S_FETCH,
        S_H_PASS,
        S_V_PASS,
        S_WRITE,
        S_NEXT,
        S_FIN
    } state_t;

    // Rounded Q0.8 product
    function automatic logic [7:0] q8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b) + 16'd128;
        return p[15:8];
    endfunction

endpackage

// File: rtl/frac_div.sv
// 16/8 restoring divider, one quotient bit per cycle, 8-bit result.
// A dividend whose high byte is not below the divisor saturates to 255.
module frac_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done,
    output logic [7:0]  quot
);

    logic [8:0] rem;
    logic [7:0] lo;
    logic [7:0] dsr;
    logic [2:0] cnt;
    logic       run;
    logic       ovf;
    logic [8:0] trial;

    assign trial = {rem[7:0], lo[7]};
    assign quot  = ovf ? 8'hFF : lo;

    // Load on start, then shift-subtract for eight cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            lo   <= '0;
            dsr  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem <= {1'b0, dividend[15:8]};
                lo  <= dividend[7:0];
                dsr <= divisor;
                cnt <= '0;
                run <= 1'b1;
                ovf <= dividend[15:8] >= divisor;
            end else if (run) begin
                if (trial >= {1'b0, dsr}) begin
                    rem <= trial - {1'b0, dsr};
                    lo  <= {lo[6:0], 1'b1};
                end else begin
                    rem <= trial;
                    lo  <= {lo[6:0], 1'b0};
                end
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bicubic_sequencer.sv
// Job controller: DDA, fraction divide, 4x4 fetch, engine passes, result write.
// Define BICUBIC_EXACT_BYPASS_EN to copy exact source hits without the engine.
module bicubic_sequencer
    import bicubic_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_start,
    input  logic [6:0]  h0,
    input  logic [6:0]  v0,
    input  logic [6:0]  sw,
    input  logic [6:0]  sh,
    input  logic [7:0]  tw,
    input  logic [7:0]  th,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_q,
    output logic        eng_start,
    output logic [7:0]  eng_x0,
    output logic [7:0]  eng_x1,
    output logic [7:0]  eng_x2,
    output logic [7:0]  eng_x3,
    output logic [7:0]  eng_p0,
    output logic [7:0]  eng_p1,
    output logic [7:0]  eng_p2,
    output logic [7:0]  eng_p3,
    input  logic [7:0]  eng_out,
    input  logic        eng_finish,
    output logic        res_wr,
    output logic [15:0] res_addr,
    output logic [7:0]  res_data
);

    localparam logic [7:0] W_LIM = 8'(IMG_W);
    localparam logic [7:0] H_LIM = 8'(IMG_H);
    localparam logic [7:0] W_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] H_MAX = 8'(IMG_H - 1);

    state_t state, nstate;

    logic [6:0]  h0_r, v0_r, sw_r, sh_r;
    logic [7:0]  tw_r, th_r;
    logic [7:0]  tx, ty;
    logic [8:0]  rem_x, rem_y;
    logic [6:0]  ix, iy;
    logic [7:0]  fx, fy;
    logic [7:0]  wx2, wx3, wy2, wy3;
    logic [7:0]  nb [16];
    logic [7:0]  hres [4];
    logic [7:0]  vres;
    logic [4:0]  fcnt;
    logic        rd_d;
    logic [3:0]  idx_d;
    logic [1:0]  hcnt;
    logic        issued;
    logic        err_r;
    logic [15:0] waddr;
    logic        byp;

    logic [7:0]  tm1_x, tm1_y;
    logic        ok;
    logic        last_col, last_row;
    logic        y_fit, x_fit;
    logic        div_start, div_done;
    logic [15:0] div_num;
    logic [7:0]  div_den, div_q;
    logic [1:0]  off_r, off_c;
    logic [7:0]  r1, c1, rc, cc, row, col;
    logic [13:0] addr_calc;
    logic        fetch_end;

    assign tm1_x    = tw_r - 8'd1;
    assign tm1_y    = th_r - 8'd1;
    assign last_col = (tx == tm1_x);
    assign last_row = (ty == tm1_y);
    assign y_fit    = rem_y < {1'b0, tm1_y};
    assign x_fit    = rem_x < {1'b0, tm1_x};

    assign ok = (sw_r >= 7'd2) && (sh_r >= 7'd2) &&
                (tw_r >= 8'd2) && (th_r >= 8'd2) &&
                ({1'b0, h0_r} + {1'b0, sw_r} <= W_LIM) &&
                ({1'b0, v0_r} + {1'b0, sh_r} <= H_LIM);

    assign div_start = (state == S_STEP_Y && y_fit) ||
                       (state == S_STEP_X && x_fit);
    assign div_num = (state == S_STEP_Y) ?
                     {rem_y[7:0], 8'h00} + {9'h0, tm1_y[7:1]} :
                     {rem_x[7:0], 8'h00} + {9'h0, tm1_x[7:1]};
    assign div_den = (state == S_STEP_Y) ? tm1_y : tm1_x;

    frac_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .done     (div_done),
        .quot     (div_q)
    );

    // Neighbourhood addressing: offsets are stored +1 so clamping stays unsigned
    assign off_r = byp ? 2'd1 : fcnt[3:2];
    assign off_c = byp ? 2'd1 : fcnt[1:0];
    assign r1 = {1'b0, v0_r} + {1'b0, iy} + {6'b0, off_r};
    assign c1 = {1'b0, h0_r} + {1'b0, ix} + {6'b0, off_c};
    assign rc = (r1 == 8'd0) ? 8'd0 : r1 - 8'd1;
    assign cc = (c1 == 8'd0) ? 8'd0 : c1 - 8'd1;
    assign row = (rc > H_MAX) ? H_MAX : rc;
    assign col = (cc > W_MAX) ? W_MAX : cc;
    assign addr_calc = IMG_AW'(row) * IMG_AW'(IMG_W) + IMG_AW'(col);

    assign fetch_end = byp ? (fcnt == 5'd1) : (fcnt == 5'd16);

`ifdef BICUBIC_EXACT_BYPASS_EN
    // Exact source hit: both fractions zero, so the pixel is copied as-is
    always_ff @(posedge clk) begin
        if (rst) begin
            byp <= 1'b0;
        end else if (state == S_POW) begin
            byp <= (fx == 8'd0) && (fy == 8'd0);
        end
    end
`else
    assign byp = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:   if (job_start) nstate = S_CHECK;
            S_CHECK:  nstate = ok ? S_STEP_Y : S_FIN;
            S_STEP_Y: if (y_fit) nstate = S_DIV_Y;
            S_DIV_Y:  if (div_done) nstate = S_STEP_X;
            S_STEP_X: if (x_fit) nstate = S_DIV_X;
            S_DIV_X:  if (div_done) nstate = S_POW;
            S_POW:    nstate = S_FETCH;
            S_FETCH:  if (fetch_end) nstate = byp ? S_WRITE : S_H_PASS;
            S_H_PASS: if (issued && eng_finish && hcnt == 2'd3) nstate = S_V_PASS;
            S_V_PASS: if (issued && eng_finish) nstate = S_WRITE;
            S_WRITE:  nstate = S_NEXT;
            S_NEXT: begin
                if (!last_col) nstate = S_STEP_X;
                else if (!last_row) nstate = S_STEP_Y;
                else nstate = S_FIN;
            end
            S_FIN:    nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        err       = (state == S_FIN) && err_r;
        img_rd    = 1'b0;
        img_addr  = '0;
        eng_start = 1'b0;
        eng_x0    = '0;
        eng_x1    = '0;
        eng_x2    = '0;
        eng_x3    = '0;
        eng_p0    = '0;
        eng_p1    = '0;
        eng_p2    = '0;
        eng_p3    = '0;
        res_wr    = 1'b0;
        res_addr  = '0;
        res_data  = '0;
        unique case (state)
            S_FETCH: begin
                img_rd   = byp ? (fcnt == 5'd0) : !fcnt[4];
                img_addr = img_rd ? addr_calc : '0;
            end
            S_H_PASS: begin
                eng_start = !issued;
                eng_x0 = Q8_ONE;
                eng_x1 = fx;
                eng_x2 = wx2;
                eng_x3 = wx3;
                eng_p0 = nb[{hcnt, 2'd0}];
                eng_p1 = nb[{hcnt, 2'd1}];
                eng_p2 = nb[{hcnt, 2'd2}];
                eng_p3 = nb[{hcnt, 2'd3}];
            end
            S_V_PASS: begin
                eng_start = !issued;
                eng_x0 = Q8_ONE;
                eng_x1 = fy;
                eng_x2 = wy2;
                eng_x3 = wy3;
                eng_p0 = hres[0];
                eng_p1 = hres[1];
                eng_p2 = hres[2];
                eng_p3 = hres[3];
            end
            S_WRITE: begin
                res_wr   = 1'b1;
                res_addr = waddr;
                res_data = vres;
            end
            default: ;
        endcase
    end

    // Datapath: job latch, DDA stepping, fetch capture, engine handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            h0_r  <= '0;
            v0_r  <= '0;
            sw_r  <= '0;
            sh_r  <= '0;
            tw_r  <= '0;
            th_r  <= '0;
            tx    <= '0;
            ty    <= '0;
            rem_x <= '0;
            rem_y <= '0;
            ix    <= '0;
            iy    <= '0;
            fx    <= '0;
            fy    <= '0;
            wx2   <= '0;
            wx3   <= '0;
            wy2   <= '0;
            wy3   <= '0;
            for (int i = 0; i < 16; i++) nb[i] <= '0;
            for (int i = 0; i < 4; i++) hres[i] <= '0;
            vres   <= '0;
            fcnt   <= '0;
            rd_d   <= 1'b0;
            idx_d  <= '0;
            hcnt   <= '0;
            issued <= 1'b0;
            err_r  <= 1'b0;
            waddr  <= '0;
        end else begin
            rd_d  <= img_rd;
            idx_d <= fcnt[3:0];
            if (rd_d) begin
                if (byp) vres <= img_q;
                else nb[idx_d] <= img_q;
            end
            unique case (state)
                S_IDLE: begin
                    if (job_start) begin
                        h0_r <= h0;
                        v0_r <= v0;
                        sw_r <= sw;
                        sh_r <= sh;
                        tw_r <= tw;
                        th_r <= th;
                    end
                end
                S_CHECK: begin
                    err_r <= !ok;
                    tx    <= '0;
                    ty    <= '0;
                    rem_x <= '0;
                    rem_y <= '0;
                    ix    <= '0;
                    iy    <= '0;
                    waddr <= '0;
                end
                S_STEP_Y: begin
                    if (!y_fit) begin
                        rem_y <= rem_y - {1'b0, tm1_y};
                        iy    <= iy + 7'd1;
                    end
                end
                S_DIV_Y: if (div_done) fy <= div_q;
                S_STEP_X: begin
                    if (!x_fit) begin
                        rem_x <= rem_x - {1'b0, tm1_x};
                        ix    <= ix + 7'd1;
                    end
                end
                S_DIV_X: if (div_done) fx <= div_q;
                S_POW: begin
                    wx2    <= q8_mul(fx, fx);
                    wx3    <= q8_mul(q8_mul(fx, fx), fx);
                    wy2    <= q8_mul(fy, fy);
                    wy3    <= q8_mul(q8_mul(fy, fy), fy);
                    fcnt   <= '0;
                    hcnt   <= '0;
                    issued <= 1'b0;
                end
                S_FETCH: if (img_rd) fcnt <= fcnt + 5'd1;
                S_H_PASS: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (eng_finish) begin
                        hres[hcnt] <= eng_out;
                        issued     <= 1'b0;
                        hcnt       <= hcnt + 2'd1;
                    end
                end
                S_V_PASS: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (eng_finish) begin
                        vres   <= eng_out;
                        issued <= 1'b0;
                    end
                end
                S_WRITE: waddr <= waddr + 16'd1;
                S_NEXT: begin
                    if (last_col) begin
                        tx    <= '0;
                        rem_x <= '0;
                        ix    <= '0;
                        if (!last_row) begin
                            ty    <= ty + 8'd1;
                            rem_y <= rem_y + {2'b0, sh_r - 7'd1};
                        end
                    end else begin
                        tx    <= tx + 8'd1;
                        rem_x <= rem_x + {2'b0, sw_r - 7'd1};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_sequencer.sv
// Directed bench for bicubic_sequencer with ROM and engine models.
// Bypass expectations follow BICUBIC_EXACT_BYPASS_EN when it is defined.
module tb_bicubic_sequencer;

    logic        clk;
    logic        rst;
    logic        job_start;
    logic [6:0]  h0, v0, sw, sh;
    logic [7:0]  tw, th;
    logic        busy, done, err;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q;
    logic        eng_start;
    logic [7:0]  eng_x0, eng_x1, eng_x2, eng_x3;
    logic [7:0]  eng_p0, eng_p1, eng_p2, eng_p3;
    logic [7:0]  eng_out;
    logic        eng_finish;
    logic        res_wr;
    logic [15:0] res_addr;
    logic [7:0]  res_data;

    bicubic_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .job_start  (job_start),
        .h0         (h0),
        .v0         (v0),
        .sw         (sw),
        .sh         (sh),
        .tw         (tw),
        .th         (th),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .img_rd     (img_rd),
        .img_addr   (img_addr),
        .img_q      (img_q),
        .eng_start  (eng_start),
        .eng_x0     (eng_x0),
        .eng_x1     (eng_x1),
        .eng_x2     (eng_x2),
        .eng_x3     (eng_x3),
        .eng_p0     (eng_p0),
        .eng_p1     (eng_p1),
        .eng_p2     (eng_p2),
        .eng_p3     (eng_p3),
        .eng_out    (eng_out),
        .eng_finish (eng_finish),
        .res_wr     (res_wr),
        .res_addr   (res_addr),
        .res_data   (res_data)
    );

    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input int r, input int c);
        int a;
        a = r * 100 + c;
        return 8'((a * 37 + 11) % 256);
    endfunction

    // ROM: data one cycle after the read strobe
    always @(posedge clk) begin
        if (img_rd) img_q <= rom(int'(img_addr) / 100, int'(img_addr) % 100);
    end

    int          nw = 0;
    logic [15:0] wa [64];
    logic [7:0]  wd [64];
    int          all_starts = 0;
    int          ndone = 0;
    bit          first_seen = 1'b0;
    logic [13:0] first_addr = '0;

    // Passive monitor of writes, starts, done pulses and first read
    always @(negedge clk) begin
        if (res_wr) begin
            if (nw < 64) begin
                wa[nw] = res_addr;
                wd[nw] = res_data;
            end
            nw++;
        end
        if (eng_start) all_starts++;
        if (done) ndone++;
        if (img_rd && !first_seen) begin
            first_seen = 1'b1;
            first_addr = img_addr;
        end
    end

    int         delay = 1;
    bit         pend = 1'b0;
    int         ecnt = 0;
    logic [7:0] cx0, cx1, cx2, cx3, cp0, cp1, cp2, cp3;
    int         stab_err = 0;
    int         extra_start = 0;
    bit         cap_got = 1'b0;
    logic [31:0] cap_x = '0;
    logic [7:0]  cap_p0 = '0;

    // Engine: identity weights return p1, any other weights return 77
    always @(negedge clk) begin
        eng_finish = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            if ({eng_x0, eng_x1, eng_x2, eng_x3, eng_p0, eng_p1, eng_p2, eng_p3} !==
                {cx0, cx1, cx2, cx3, cp0, cp1, cp2, cp3}) stab_err++;
            if (eng_start) extra_start++;
            if (ecnt == 0) begin
                eng_finish = 1'b1;
                eng_out = (cx0 == 8'd255 && cx1 == 0 && cx2 == 0 && cx3 == 0) ? cp1 : 8'd77;
                pend = 1'b0;
            end else begin
                ecnt--;
            end
        end else if (eng_start) begin
            {cx0, cx1, cx2, cx3} = {eng_x0, eng_x1, eng_x2, eng_x3};
            {cp0, cp1, cp2, cp3} = {eng_p0, eng_p1, eng_p2, eng_p3};
            pend = 1'b1;
            ecnt = delay - 1;
            if (!cap_got && eng_x1 != 8'd0) begin
                cap_got = 1'b1;
                cap_x   = {eng_x0, eng_x1, eng_x2, eng_x3};
                cap_p0  = eng_p0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [6:0] a, input logic [6:0] b,
                             input logic [6:0] c, input logic [6:0] d,
                             input logic [7:0] e, input logic [7:0] f);
        tick();
        h0 = a; v0 = b; sw = c; sh = d; tw = e; th = f;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke, output logic e);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        e = err;
        if (poke) begin
            sw = 7'd1;
            job_start = 1'b1;
        end
        tick();
        job_start = 1'b0;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   n0, s0, d0;
        rst = 1'b1;
        job_start = 1'b0;
        h0 = '0; v0 = '0; sw = '0; sh = '0; tw = '0; th = '0;
        eng_out = '0;
        eng_finish = 1'b0;
        img_q = '0;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctrl", {26'd0, busy, done, err, img_rd, eng_start, res_wr}, 32'd0);
        end
        chk("idle_bus", {2'd0, img_addr, res_addr} | {eng_x0, eng_x1, eng_x2, eng_x3}
            | {eng_p0, eng_p1, eng_p2, eng_p3} | {24'd0, res_data}, 32'd0);
        chk("idle_activity", all_starts + nw, 0);

        n0 = nw;
        start_job(7'd0, 7'd0, 7'd1, 7'd4, 8'd4, 8'd4);
        chk("rej_check_done", {30'd0, done, err}, 32'd0);
        tick();
        chk("rej_done_err", {30'd0, done, err}, 32'd3);
        tick();
        chk("rej_after", {30'd0, busy, done}, 32'd0);
        chk("rej_no_write", nw - n0, 0);

        start_job(7'd99, 7'd0, 7'd2, 7'd2, 8'd2, 8'd2);
        wait_done(10, 1'b0, e);
        chk("rej_h_overrun", {31'd0, e}, 32'd1);
        start_job(7'd0, 7'd0, 7'd2, 7'd2, 8'd1, 8'd2);
        wait_done(10, 1'b0, e);
        chk("rej_tw1", {31'd0, e}, 32'd1);
        chk("rej_no_write2", nw - n0, 0);

        n0 = nw;
        s0 = all_starts;
        first_seen = 1'b0;
        start_job(7'd0, 7'd0, 7'd4, 7'd4, 8'd4, 8'd4);
        wait_done(3000, 1'b0, e);
        chk("id_err", {31'd0, e}, 32'd0);
        chk("id_first_addr", {18'd0, first_addr}, 32'd0);
        chk("id_nwrites", nw - n0, 16);
        for (int k = 0; k < 16; k++) begin
            chk("id_addr", {16'd0, wa[n0 + k]}, k);
            chk("id_data", {24'd0, wd[n0 + k]}, {24'd0, rom(k / 4, k % 4)});
        end
`ifdef BICUBIC_EXACT_BYPASS_EN
        chk("id_starts", all_starts - s0, 0);
`else
        chk("id_starts", all_starts - s0, 80);
`endif

        n0 = nw;
        d0 = ndone;
        cap_got = 1'b0;
        start_job(7'd10, 7'd20, 7'd4, 7'd2, 8'd7, 8'd2);
        repeat (5) tick();
        sw = 7'd1;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        sw = 7'd4;
        wait_done(5000, 1'b1, e);
        chk("sc_err", {31'd0, e}, 32'd0);
        repeat (3) tick();
        chk("sc_dropped_start", {31'd0, busy}, 32'd0);
        chk("sc_one_done", ndone - d0, 1);
        chk("sc_nwrites", nw - n0, 14);
        chk("sc_xw", cap_x, 32'hFF804020);
        chk("sc_p0", {24'd0, cap_p0}, {24'd0, rom(19, 9)});
        chk("sc_px0", {24'd0, wd[n0 + 0]}, {24'd0, rom(20, 10)});
        chk("sc_px1", {24'd0, wd[n0 + 1]}, 32'd77);
        chk("sc_px2", {24'd0, wd[n0 + 2]}, {24'd0, rom(20, 11)});
        chk("sc_px5", {24'd0, wd[n0 + 5]}, 32'd77);
        chk("sc_px6", {24'd0, wd[n0 + 6]}, {24'd0, rom(20, 13)});
        chk("sc_px7", {24'd0, wd[n0 + 7]}, {24'd0, rom(21, 10)});
        chk("sc_px8", {24'd0, wd[n0 + 8]}, 32'd77);
        chk("sc_last_addr", {16'd0, wa[n0 + 13]}, 32'd13);
        chk("sc_stable", stab_err + extra_start, 0);

        delay = 20;
        s0 = all_starts;
        start_job(7'd10, 7'd20, 7'd4, 7'd2, 8'd7, 8'd2);
        begin
            int n;
            n = 0;
            while (all_starts - s0 < 2 && n < 3000) begin
                tick();
                n++;
            end
            chk("slow_two_starts", {31'd0, all_starts - s0 >= 2}, 32'd1);
        end
        repeat (5) tick();
        chk("slow_stable", stab_err, 0);
        chk("slow_no_extra", extra_start, 0);
        n0 = nw;
        s0 = all_starts;
        d0 = ndone;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_idle", {30'd0, busy, done}, 32'd0);
        repeat (40) tick();
        chk("rst_quiet", (nw - n0) + (all_starts - s0) + (ndone - d0), 0);

        delay = 1;
        n0 = nw;
        start_job(7'd98, 7'd98, 7'd2, 7'd2, 8'd2, 8'd2);
        wait_done(2000, 1'b0, e);
        chk("edge_err", {31'd0, e}, 32'd0);
        chk("edge_nwrites", nw - n0, 4);
        chk("edge_d0", {24'd0, wd[n0 + 0]}, {24'd0, rom(98, 98)});
        chk("edge_d1", {24'd0, wd[n0 + 1]}, {24'd0, rom(98, 99)});
        chk("edge_d2", {24'd0, wd[n0 + 2]}, {24'd0, rom(99, 98)});
        chk("edge_d3", {24'd0, wd[n0 + 3]}, {24'd0, rom(99, 99)});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bicubic_sequencer.md
# bicubic_sequencer

Job-level controller that drives the bicubic engine from the initiator side. For each target pixel of a scaled window it computes source coordinates and fractions, fetches the 4x4 neighbourhood from image ROM, and issues four horizontal and one vertical engine requests. It writes the result to result SRAM in row-major order. It sits between the top-level job interface and the engine/memories.

## Interface
- IMG_W, 100, source image width in pixels
- IMG_H, 100, source image height in pixels
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_start  in  1  one-cycle job request; ignored while busy
- h0, v0  in  7 each  window origin (column, row)
- sw, sh  in  7 each  source window width, height
- tw, th  in  8 each  target width, height
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  valid with done; job rejected
- img_rd  out  1  ROM read strobe
- img_addr  out  14  row*IMG_W+col
- img_q  in  8  ROM data, valid the cycle after img_rd
- eng_start  out  1  one-cycle engine request
- eng_x0..eng_x3  out  8 each  Q0.8 weights {1, t, t², t³}
- eng_p0..eng_p3  out  8 each  pixel operands
- eng_out  in  8  engine result
- eng_finish  in  1  one-cycle engine completion
- res_wr, res_addr, res_data  out  1/16/8  result SRAM write

## Operation
- States: IDLE, CHECK, STEP_Y, DIV_Y, STEP_X, DIV_X, POW, FETCH, H_PASS, V_PASS, WRITE, NEXT, FIN.
- CHECK: reject if sw<2, sh<2, tw<2, th<2, h0+sw>IMG_W or v0+sh>IMG_H. Rejection raises done=1 and err=1 in the next cycle, makes no writes, and returns to IDLE.
- DDA per axis: the remainder accumulator gains (s-1) per target step, then (t-1) is subtracted and the integer index incremented, one subtract per cycle, until remainder < t-1. Row step runs once per target row; column step runs per pixel; both reset to 0 at row/job start.
- Fraction: f = ((rem<<8) + ((t-1)>>1)) / (t-1), computed by the divider. The result saturates to 255.
- POW: t² = (f*f+128)>>8 and t³ = (t²*f+128)>>8. The constant term is driven as 8'd255 and represents 1.0.
- FETCH: 16 reads, rows iy-1..iy+2 by columns ix-1..ix+2. Source indices are origin+int±k, clamped to [0, IMG_W-1] / [0, IMG_H-1].
- H_PASS: four engine requests, one per neighbourhood row, using x weights. Each result is latched on eng_finish.
- V_PASS: one request with y weights and the four latched results as P.
- WRITE: res_data = engine result; res_addr increments from 0 to tw*th-1.
- NEXT: advance column, wrapping to the next row. After the last pixel, go to FIN: done=1, err=0, then IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; res_addr 0.
- eng_start is a single-cycle pulse. eng_x*/eng_p* are held stable from the pulse until the cycle eng_finish is sampled. The next eng_start comes no earlier than the cycle after eng_finish.
- eng_finish arriving outside a wait state is ignored.
- FETCH asserts img_rd for 16 consecutive cycles; the last datum is captured one cycle later.
- Each divide takes 9 cycles (start plus 8 iterations).
- job_start while busy is dropped. job_start in the same cycle as done is dropped.
- rst mid-job: state goes to IDLE in the next cycle; no res_wr, no eng_start, no done pulse.
- The res_wr pulse lasts one cycle; address and data are valid in the same cycle.

## Configuration
- BICUBIC_EXACT_BYPASS_EN defined: a pixel with both fractions 0 reads only pixel (iy, ix) via one img_rd and writes it directly. No engine requests are issued for that pixel.
- BICUBIC_EXACT_BYPASS_EN undefined: every pixel goes through the full FETCH/H_PASS/V_PASS sequence.

## Structure
- bicubic_pkg holds:
  - IMG_W/IMG_H defaults
  - state enum
  - Q0.8 ONE constant (8'd255)
  - address width constants
- Sub-module frac_div: 16/8 restoring divider with start/done, 8-iteration sequential, 8-bit quotient.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0; no img_rd, eng_start or res_wr.
- With bypass enabled, h0=v0=0, sw=tw=sh=th=4 -> 16 writes, res_data equals ROM (r,c), zero eng_start, done with err=0.
- sw=4, tw=7, sh=th=2 at pixel tx=1 -> f=128 and eng_x = {255,128,64,32} on H_PASS. The engine model returns 77 -> res_data=77.
- h0=0, v0=0, any pixel with ix=0 -> column -1 fetches map to col 0. img_addr for the first read is 0.
- sw=1 -> done and err pulse together one cycle after CHECK; no res_wr.
- Engine model delays eng_finish by 20 cycles -> eng_x*/eng_p* stay stable and there is no second eng_start. Asserting rst mid-H_PASS -> IDLE next cycle with no done pulse.
